// File: rtl/axi_xbar_arb_pkg.sv
// ============================================================================
// Module      : axi_xbar_arb_pkg
// Description : Shared constants and sizing helpers for the master-port
//               arbiter (QoS width, select index widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_xbar_arb_pkg;

  localparam int QOS_W = 4;

  // Width of an index selecting one of n items; never less than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_xbar_rr_pick.sv
// ============================================================================
// Module      : axi_xbar_rr_pick
// Description : Round-robin picker with handshake lock; optional QoS compare
//               enabled by AXI_XBAR_ARB_QOS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_xbar_rr_pick
  import axi_xbar_arb_pkg::*;
#(
  parameter int NO_PORTS = 4,
  localparam int IW = idx_width(NO_PORTS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NO_PORTS-1:0]       i_valid,
  input  logic                      i_en,
  input  logic                      i_ready,
`ifdef AXI_XBAR_ARB_QOS_EN
  input  logic [NO_PORTS*QOS_W-1:0] i_qos,
`endif
  output logic                      o_valid,
  output logic [IW-1:0]             o_sel,
  output logic [NO_PORTS-1:0]       o_ready
);

  localparam int SW = IW + 1;

  logic [IW-1:0]       r_ptr;
  logic                r_lock;
  logic [IW-1:0]       r_lock_sel;
  logic [NO_PORTS-1:0] w_req;
  logic [IW-1:0]       w_pick;
  logic                w_found;
  logic [SW-1:0]       w_sum;
  logic [IW-1:0]       w_idx;

  assign w_req = i_valid & {NO_PORTS{i_en}};

`ifdef AXI_XBAR_ARB_QOS_EN
  logic [QOS_W-1:0] w_qos [NO_PORTS];
  logic [QOS_W-1:0] w_best;

  for (genvar g = 0; g < NO_PORTS; g++) begin : g_qos
    assign w_qos[g] = i_qos[g*QOS_W +: QOS_W];
  end
`endif

  // Scan in priority order from the pointer; strict compare keeps the
  // earliest requester among equal-QoS ties.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
`ifdef AXI_XBAR_ARB_QOS_EN
    w_best  = '0;
`endif
    for (int k = 0; k < NO_PORTS; k++) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(NO_PORTS)) w_sum = w_sum - SW'(NO_PORTS);
      w_idx = w_sum[IW-1:0];
`ifdef AXI_XBAR_ARB_QOS_EN
      if (w_req[w_idx] && (!w_found || (w_qos[w_idx] > w_best))) begin
        w_best  = w_qos[w_idx];
`else
      if (w_req[w_idx] && !w_found) begin
`endif
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_sel   = r_lock ? r_lock_sel : w_pick;
  assign o_valid = r_lock ? w_req[r_lock_sel] : w_found;
  assign o_ready = {{(NO_PORTS-1){1'b0}}, (i_ready && o_valid)} << o_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= '0;
    end else if (o_valid && i_ready) begin
      r_ptr  <= (o_sel == IW'(NO_PORTS-1)) ? '0 : o_sel + IW'(1);
      r_lock <= 1'b0;
    end else if (o_valid) begin
      r_lock     <= 1'b1;
      r_lock_sel <= o_sel;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_xbar_mst_arbiter.sv
// ============================================================================
// Module      : axi_xbar_mst_arbiter
// Description : AW/AR arbitration and W-order steering for one crossbar
//               master port. QoS arbitration via AXI_XBAR_ARB_QOS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_xbar_mst_arbiter
  import axi_xbar_arb_pkg::*;
#(
  parameter int NoSlvPorts = 4,
  parameter int MaxWTrans  = 8,
  localparam int IW = idx_width(NoSlvPorts)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NoSlvPorts-1:0]       aw_valid_i,
  output logic [NoSlvPorts-1:0]       aw_ready_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [IW-1:0]               aw_sel_o,
  input  logic [NoSlvPorts-1:0]       w_valid_i,
  input  logic [NoSlvPorts-1:0]       w_last_i,
  output logic [NoSlvPorts-1:0]       w_ready_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [IW-1:0]               w_sel_o,
  input  logic [NoSlvPorts-1:0]       ar_valid_i,
  output logic [NoSlvPorts-1:0]       ar_ready_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [IW-1:0]               ar_sel_o,
`ifdef AXI_XBAR_ARB_QOS_EN
  input  logic [NoSlvPorts*QOS_W-1:0] aw_qos_i,
  input  logic [NoSlvPorts*QOS_W-1:0] ar_qos_i,
`endif
  output logic                        w_busy_o
);

  localparam int PW = idx_width(MaxWTrans);
  localparam int CW = idx_width(MaxWTrans + 1);

  logic [IW-1:0] r_fifo [MaxWTrans];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_head;

  // Full is judged on the registered count so W never feeds AW ready.
  assign w_full  = (r_cnt == CW'(MaxWTrans));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rptr];

  axi_xbar_rr_pick #(.NO_PORTS(NoSlvPorts)) u_aw_pick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_valid (aw_valid_i),
    .i_en    (!w_full),
    .i_ready (aw_ready_i),
`ifdef AXI_XBAR_ARB_QOS_EN
    .i_qos   (aw_qos_i),
`endif
    .o_valid (aw_valid_o),
    .o_sel   (aw_sel_o),
    .o_ready (aw_ready_o)
  );

  axi_xbar_rr_pick #(.NO_PORTS(NoSlvPorts)) u_ar_pick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_valid (ar_valid_i),
    .i_en    (1'b1),
    .i_ready (ar_ready_i),
`ifdef AXI_XBAR_ARB_QOS_EN
    .i_qos   (ar_qos_i),
`endif
    .o_valid (ar_valid_o),
    .o_sel   (ar_sel_o),
    .o_ready (ar_ready_o)
  );

  assign w_push    = aw_valid_o && aw_ready_i;
  assign w_sel_o   = w_empty ? '0 : w_head;
  assign w_valid_o = !w_empty && w_valid_i[w_head];
  assign w_ready_o = {{(NoSlvPorts-1){1'b0}}, (w_ready_i && !w_empty)} << w_head;
  assign w_pop     = w_valid_o && w_ready_i && w_last_i[w_head];
  assign w_busy_o  = r_busy;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= aw_sel_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(MaxWTrans-1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(MaxWTrans-1)) ? '0 : r_rptr + PW'(1);
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

endmodule

`default_nettype wire

// File: doc/axi_xbar_mst_arbiter.md
# axi_xbar_mst_arbiter

Control-only scheduler for one crossbar master port. It arbitrates the AW and AR channels among the `NoSlvPorts` per-slave-port requests that a crossbar routes to that master port. It also records write-grant order so W beats are steered to the matching slave port until `wlast`. The block drives mux select indices and the valid/ready handshakes; the payload mux sits outside, in the master-port multiplexer that instantiates it.

## Interface
Parameters:
- `NoSlvPorts`, default 4: number of competing slave ports; must be ≥ 2.
- `MaxWTrans`, default 8: depth of the W-order FIFO, i.e. the maximum number of outstanding write bursts whose W data is incomplete; must be ≥ 1.

Ports (`IW` = `idx_width(NoSlvPorts)`):
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `aw_valid_i` input NoSlvPorts: AW valid per slave port.
- `aw_ready_o` output NoSlvPorts: AW ready per slave port.
- `aw_valid_o` output 1: AW valid toward the master port.
- `aw_ready_i` input 1: AW ready from the master port.
- `aw_sel_o` output IW: AW payload mux select.
- `w_valid_i` input NoSlvPorts: W valid per slave port.
- `w_last_i` input NoSlvPorts: `wlast` per slave port.
- `w_ready_o` output NoSlvPorts: W ready per slave port.
- `w_valid_o` output 1: W valid toward the master port.
- `w_ready_i` input 1: W ready from the master port.
- `w_sel_o` output IW: W payload mux select.
- `ar_valid_i` input NoSlvPorts: AR valid per slave port.
- `ar_ready_o` output NoSlvPorts: AR ready per slave port.
- `ar_valid_o` output 1: AR valid toward the master port.
- `ar_ready_i` input 1: AR ready from the master port.
- `ar_sel_o` output IW: AR payload mux select.
- `w_busy_o` output 1: the W-order FIFO is non-empty.

## Operation
**AW arbitration**
- Round-robin; priority pointer `aw_ptr` starts at 0.
- The winner is the first index at or after `aw_ptr`, modulo N, with `aw_valid_i` set.
- Requests are gated by `!wfifo_full`. If the FIFO is full, `aw_valid_o` = 0 and all `aw_ready_o` = 0.
- Lock: once `aw_valid_o` = 1 without `aw_ready_i`, `aw_sel_o` and the grant are frozen until the handshake. Other requesters raising valid do not change the selection.
- Handshake (`aw_valid_o && aw_ready_i`):
  - `aw_ptr` ← (sel+1) mod N.
  - Lock clears.
  - sel is pushed into the W-order FIFO.
- `aw_ready_o[i]` = `aw_ready_i && granted(i) && !wfifo_full`.

**W steering**
- `w_sel_o` = FIFO head, or 0 when the FIFO is empty.
- `w_valid_o` = `!empty && w_valid_i[head]`.
- `w_ready_o[head]` = `w_ready_i && !empty`; all other bits are 0.
- On a W handshake with `w_last_i[head]`, the head is popped.
- W data presented before its AW is granted is stalled; W never leads AW at this port.

**FIFO boundaries**
- The full check uses the registered count only. When the FIFO is full, a push is refused even if a pop occurs in the same cycle, so there is no ready-to-ready combinational path from W to AW.
- A push and a pop in the same cycle at a non-full, non-empty count leave the count unchanged.
- A pop when empty cannot occur, because `w_ready_o` = 0.

**AR arbitration**
- Identical to AW: independent pointer `ar_ptr` and its own lock, with no FIFO gating.

## Timing
- Arbitration is combinational, with zero-cycle latency: `aw_valid_i[k]` at cycle t gives `aw_valid_o` at cycle t.
- The FIFO push is registered. W for a burst is accepted no earlier than the cycle after its AW handshake.
- Pointers and locks update on the rising edge after a handshake.
- Reset (`rst_i` = 1 at an edge) returns to the reset state regardless of outstanding transfers; in-flight bursts are discarded:
  - pointers = 0;
  - locks cleared;
  - FIFO empty.
- Output values in and out of reset:
  - `w_busy_o` is registered and is 0 after reset.
  - All other outputs are combinational. With the registered state at its reset values:
    - `aw_valid_o`, `ar_valid_o`, `w_valid_o` = 0 whenever no valid input is asserted;
    - `w_valid_o` and all `w_ready_o` = 0 because the FIFO is empty;
    - all `aw_ready_o` and `ar_ready_o` = 0 whenever no request is granted;
    - `aw_sel_o`, `ar_sel_o`, `w_sel_o` = 0 when idle.

## Configuration
- `AXI_XBAR_ARB_QOS_EN`
- Defined:
  - Adds `aw_qos_i` and `ar_qos_i` inputs, `NoSlvPorts`×4 each.
  - The winner is the valid requester with the highest QoS value.
  - Ties are broken round-robin from the pointer.
  - The lock rule still applies, so QoS changes on a locked request are ignored.
- Undefined: the ports are absent and arbitration is pure round-robin.

## Structure
- Package `axi_xbar_arb_pkg` holds the QoS width constant (4) and a function computing `idx_width`-based select types.
- Sub-module `axi_xbar_rr_pick` holds the pointer register, lock register, winner computation and optional QoS compare. It is instantiated twice, for AW and AR.
- The W-order FIFO is inline: a register array plus read/write pointers and a count.

## Test plan
- Idle, then `aw_valid_i` = 4'b1111 held with `aw_ready_i` = 1 → grants in order 0, 1, 2, 3, 0, one per cycle.
- `aw_valid_i` = 4'b0100 with `aw_ready_i` = 0 for 3 cycles, and port 0 raises valid in cycle 2 → `aw_sel_o` stays 2 until `aw_ready_i` = 1.
- AW grants to ports 3 then 1, each followed by a 2-beat burst, with both ports offering W at once → beats from port 3 until its `wlast`, then port 1; `w_busy_o` falls the cycle after the final pop.
- `MaxWTrans` = 2 with `w_ready_i` = 0 → exactly 2 AW accepted, then `aw_ready_o` = 0. Raising `w_ready_i` and completing one burst → AW is accepted again the next cycle.
- AR and AW requests from the same port in the same cycle → both granted independently in one cycle; the pointers advance separately.
- Assert `rst_i` with 1 burst outstanding → next cycle `w_busy_o` = 0, `w_valid_o` = 0, and the pointers are 0 (the next grant from 4'b1111 is 0). With `AXI_XBAR_ARB_QOS_EN`: QoS {1, 7, 7, 3} on all-valid → grants 1 then 2.
